// File: rtl/csr_user_counter_file.sv
// rtl/csr_user_counter_file.sv - FP status and counter CSR responder on the commit-stage request channel
module csr_user_counter_file #(
    parameter int COUNTER_W = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [86:0] req_cpu_csr_i,
    output logic        csr_resp_valid_o,
    output logic [63:0] csr_rdata_o,
    output logic        csr_illegal_o,
    output logic [2:0]  frm_o,
    output logic [4:0]  fflags_o
);

    typedef enum logic [2:0] {
        CMD_NOPE   = 3'd0,
        CMD_WRITE  = 3'd1,
        CMD_SET    = 3'd2,
        CMD_CLEAR  = 3'd3,
        CMD_READ   = 3'd4,
        CMD_SYS    = 3'd5,
        CMD_N2     = 3'd6,
        CMD_VSELVL = 3'd7
    } csr_cmd_t;

    // req_cpu_csr_t, packed MSB first: addr[86:75] cmd[74:72] data[71:8] exc[7] retire[6:5] fp_status[4:0]
    typedef struct packed {
        logic [11:0] csr_rw_addr;
        csr_cmd_t    csr_rw_cmd;
        logic [63:0] csr_rw_data;
        logic        csr_exception;
        logic [1:0]  csr_retire;
        logic [4:0]  fp_status;
    } req_cpu_csr_t;

    localparam logic [11:0] ADDR_FFLAGS   = 12'h001;
    localparam logic [11:0] ADDR_FRM      = 12'h002;
    localparam logic [11:0] ADDR_FCSR     = 12'h003;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;

    req_cpu_csr_t req;
    assign req = req_cpu_csr_t'(req_cpu_csr_i);

    logic [4:0]           fflags_q;
    logic [2:0]           frm_q;
    logic [63:0]          mscratch_q;
    logic [COUNTER_W-1:0] cycle_q;
    logic [COUNTER_W-1:0] instret_q;

    logic        cmd_accepted;
    logic        is_read;
    logic        addr_mapped;
    logic        addr_ro;
    logic        req_illegal;
    logic        do_write;
    logic [63:0] old_val;
    logic [63:0] new_val;

    logic hit_fflags;
    logic hit_frm;
    logic hit_fcsr;
    logic hit_mscratch;
    logic hit_mcycle;
    logic hit_minstret;
    logic hit_cycle;
    logic hit_instret;

    logic [COUNTER_W-1:0] retire_cnt;

    assign hit_fflags   = (req.csr_rw_addr == ADDR_FFLAGS);
    assign hit_frm      = (req.csr_rw_addr == ADDR_FRM);
    assign hit_fcsr     = (req.csr_rw_addr == ADDR_FCSR);
    assign hit_mscratch = (req.csr_rw_addr == ADDR_MSCRATCH);
    assign hit_mcycle   = (req.csr_rw_addr == ADDR_MCYCLE);
    assign hit_minstret = (req.csr_rw_addr == ADDR_MINSTRET);
    assign hit_cycle    = (req.csr_rw_addr == ADDR_CYCLE);
    assign hit_instret  = (req.csr_rw_addr == ADDR_INSTRET);

    assign cmd_accepted = !req.csr_exception &&
                          ((req.csr_rw_cmd == CMD_READ)  || (req.csr_rw_cmd == CMD_WRITE) ||
                           (req.csr_rw_cmd == CMD_SET)   || (req.csr_rw_cmd == CMD_CLEAR));
    assign is_read      = (req.csr_rw_cmd == CMD_READ);

    assign addr_mapped  = hit_fflags | hit_frm | hit_fcsr | hit_mscratch |
                          hit_mcycle | hit_minstret | hit_cycle | hit_instret;
    assign addr_ro      = hit_cycle | hit_instret;
    assign req_illegal  = !addr_mapped || (addr_ro && !is_read);
    assign do_write     = cmd_accepted && !req_illegal && !is_read;

    // Old value is the pre-update state, so counter reads see the value before this cycle's increment
    always_comb begin
        old_val = 64'd0;
        if (hit_fflags) begin
            old_val = {59'd0, fflags_q};
        end else if (hit_frm) begin
            old_val = {61'd0, frm_q};
        end else if (hit_fcsr) begin
            old_val = {56'd0, frm_q, fflags_q};
        end else if (hit_mscratch) begin
            old_val = mscratch_q;
        end else if (hit_mcycle || hit_cycle) begin
            old_val = 64'(cycle_q);
        end else if (hit_instret || hit_minstret) begin
            old_val = 64'(instret_q);
        end
    end

    always_comb begin
        new_val = old_val;
        case (req.csr_rw_cmd)
            CMD_WRITE: new_val = req.csr_rw_data;
            CMD_SET:   new_val = old_val | req.csr_rw_data;
            CMD_CLEAR: new_val = old_val & ~req.csr_rw_data;
            default:   new_val = old_val;
        endcase
    end

    assign retire_cnt = COUNTER_W'(req.csr_retire[0]) + COUNTER_W'(req.csr_retire[1]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            csr_resp_valid_o <= 1'b0;
            csr_illegal_o    <= 1'b0;
            csr_rdata_o      <= 64'd0;
        end else begin
            csr_resp_valid_o <= cmd_accepted;
            csr_illegal_o    <= cmd_accepted && req_illegal;
            csr_rdata_o      <= (cmd_accepted && !req_illegal) ? old_val : 64'd0;
        end
    end

    // Flags raised by the FPU this cycle are OR-ed on top of any software write
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fflags_q <= 5'd0;
            frm_q    <= 3'd0;
        end else begin
            if (do_write && (hit_fflags || hit_fcsr)) begin
                fflags_q <= new_val[4:0] | req.fp_status;
            end else begin
                fflags_q <= fflags_q | req.fp_status;
            end
            if (do_write && hit_frm) begin
                frm_q <= new_val[2:0];
            end else if (do_write && hit_fcsr) begin
                frm_q <= new_val[7:5];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mscratch_q <= 64'd0;
        end else if (do_write && hit_mscratch) begin
            mscratch_q <= new_val;
        end
    end

    // A software write to a counter replaces that cycle's increment
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (do_write && hit_mcycle) begin
                cycle_q <= new_val[COUNTER_W-1:0];
            end else begin
                cycle_q <= cycle_q + COUNTER_W'(1);
            end
            if (do_write && hit_minstret) begin
                instret_q <= new_val[COUNTER_W-1:0];
            end else begin
                instret_q <= instret_q + retire_cnt;
            end
        end
    end

    assign frm_o    = frm_q;
    assign fflags_o = fflags_q;

endmodule

// File: tb/tb_csr_user_counter_file.sv
// tb/tb_csr_user_counter_file.sv - bench for csr_user_counter_file, 64-bit and 8-bit counter instances
module tb_csr_user_counter_file;

    localparam logic [2:0] C_NOPE = 3'd0, C_WRITE = 3'd1, C_SET = 3'd2, C_CLEAR = 3'd3;
    localparam logic [2:0] C_READ = 3'd4, C_SYS = 3'd5, C_N2 = 3'd6, C_VSELVL = 3'd7;

    typedef struct packed {
        logic [11:0] csr_rw_addr;
        logic [2:0]  csr_rw_cmd;
        logic [63:0] csr_rw_data;
        logic        csr_exception;
        logic [1:0]  csr_retire;
        logic [4:0]  fp_status;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    req_t req;

    logic        v64, v8, ill64, ill8;
    logic [63:0] rd64, rd8;
    logic [2:0]  frm64, frm8;
    logic [4:0]  ff64, ff8;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    csr_user_counter_file dut64 (
        .clk_i(clk), .rst_i(rst), .req_cpu_csr_i(req),
        .csr_resp_valid_o(v64), .csr_rdata_o(rd64), .csr_illegal_o(ill64),
        .frm_o(frm64), .fflags_o(ff64)
    );

    csr_user_counter_file #(.COUNTER_W(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .req_cpu_csr_i(req),
        .csr_resp_valid_o(v8), .csr_rdata_o(rd8), .csr_illegal_o(ill8),
        .frm_o(frm8), .fflags_o(ff8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: architectural CSR values as plain variables; index 0 = 64-bit counters, 1 = 8-bit counters
    logic [4:0]  m_fflags = '0;
    logic [2:0]  m_frm = '0;
    logic [63:0] m_mscratch = '0;
    logic [63:0] m_cyc [2];
    logic [63:0] m_ins [2];
    logic [63:0] cmask [2];
    logic        e_valid = 1'b0;
    logic        e_ill = 1'b0;
    logic [63:0] e_rdata [2];
    bit          model_live = 1'b0;

    initial begin
        cmask[0] = '1;
        cmask[1] = 64'hFF;
    end

    function automatic logic [63:0] csr_value(input logic [11:0] a, input int k);
        case (a)
            12'h001: return {59'd0, m_fflags};
            12'h002: return {61'd0, m_frm};
            12'h003: return {56'd0, m_frm, m_fflags};
            12'h340: return m_mscratch;
            12'hB00, 12'hC00: return m_cyc[k];
            12'hB02, 12'hC02: return m_ins[k];
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] apply_cmd(input logic [2:0] c, input logic [63:0] o, input logic [63:0] d);
        if (c == C_WRITE) return d;
        if (c == C_SET) return o | d;
        return o & ~d;
    endfunction

    always @(posedge clk) begin
        bit          acc, mapped, legal, wr;
        logic [63:0] old0, nv0, oldk, nvk;
        logic [4:0]  nff;
        logic [2:0]  nfrm;
        logic [63:0] nms;
        logic [63:0] ret;
        if (rst) begin
            m_fflags = '0; m_frm = '0; m_mscratch = '0;
            for (int k = 0; k < 2; k++) begin
                m_cyc[k] = '0; m_ins[k] = '0; e_rdata[k] = '0;
            end
            e_valid = 1'b0; e_ill = 1'b0;
            model_live = 1'b1;
        end else begin
            acc    = (req.csr_rw_cmd inside {C_READ, C_WRITE, C_SET, C_CLEAR}) && !req.csr_exception;
            mapped = req.csr_rw_addr inside {12'h001, 12'h002, 12'h003, 12'h340,
                                             12'hB00, 12'hB02, 12'hC00, 12'hC02};
            legal  = mapped && !((req.csr_rw_addr inside {12'hC00, 12'hC02}) && req.csr_rw_cmd != C_READ);
            wr     = acc && legal && req.csr_rw_cmd != C_READ;
            e_valid = acc;
            e_ill   = acc && !legal;
            ret = 64'(req.csr_retire[0]) + 64'(req.csr_retire[1]);

            old0 = csr_value(req.csr_rw_addr, 0);
            nv0  = apply_cmd(req.csr_rw_cmd, old0, req.csr_rw_data);
            nff  = m_fflags | req.fp_status;
            nfrm = m_frm;
            nms  = m_mscratch;
            if (wr && req.csr_rw_addr == 12'h001) nff = nv0[4:0] | req.fp_status;
            if (wr && req.csr_rw_addr == 12'h003) begin
                nff  = nv0[4:0] | req.fp_status;
                nfrm = nv0[7:5];
            end
            if (wr && req.csr_rw_addr == 12'h002) nfrm = nv0[2:0];
            if (wr && req.csr_rw_addr == 12'h340) nms = nv0;

            for (int k = 0; k < 2; k++) begin
                oldk = csr_value(req.csr_rw_addr, k);
                nvk  = apply_cmd(req.csr_rw_cmd, oldk, req.csr_rw_data);
                e_rdata[k] = (acc && legal) ? oldk : 64'd0;
                if (wr && req.csr_rw_addr == 12'hB00) m_cyc[k] = nvk & cmask[k];
                else                                  m_cyc[k] = (m_cyc[k] + 1) & cmask[k];
                if (wr && req.csr_rw_addr == 12'hB02) m_ins[k] = nvk & cmask[k];
                else                                  m_ins[k] = (m_ins[k] + ret) & cmask[k];
            end
            m_fflags = nff; m_frm = nfrm; m_mscratch = nms;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("valid64", 64'(v64), 64'(e_valid));
            chk("valid8", 64'(v8), 64'(e_valid));
            if (e_valid) begin
                chk("illegal64", 64'(ill64), 64'(e_ill));
                chk("illegal8", 64'(ill8), 64'(e_ill));
                chk("rdata64", rd64, e_rdata[0]);
                chk("rdata8", rd8, e_rdata[1]);
            end
            chk("frm64", 64'(frm64), 64'(m_frm));
            chk("fflags64", 64'(ff64), 64'(m_fflags));
            chk("frm8", 64'(frm8), 64'(m_frm));
            chk("fflags8", 64'(ff8), 64'(m_fflags));
        end
    end

    task automatic set_idle();
        req = '0;
        req.csr_rw_cmd = C_NOPE;
    endtask

    task automatic issue(input logic [11:0] a, input logic [2:0] c, input logic [63:0] d,
                         input logic exc = 1'b0, input logic [1:0] ret = 2'b00,
                         input logic [4:0] fp = 5'd0);
        req.csr_rw_addr   = a;
        req.csr_rw_cmd    = c;
        req.csr_rw_data   = d;
        req.csr_exception = exc;
        req.csr_retire    = ret;
        req.fp_status     = fp;
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic idle_cycle(input logic [1:0] ret);
        req.csr_retire = ret;
        @(posedge clk);
        #1;
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_rst_valid", 64'(v64), 64'd0);
        chk("lit_rst_rdata", rd64, 64'd0);
        chk("lit_rst_fflags", 64'(ff64), 64'd0);
        chk("lit_rst_frm", 64'(frm64), 64'd0);
        rst = 1'b0;

        issue(12'hC00, C_READ, 64'd0);
        chk("lit_cycle_first", rd64, 64'd0);
        issue(12'hC00, C_READ, 64'd0);
        chk("lit_cycle_second", rd64, 64'd1);

        issue(12'h003, C_WRITE, 64'hFFFF_FFFF_FFFF_FFE5);
        chk("lit_fcsr_wr_rdata", rd64, 64'd0);
        chk("lit_fcsr_wr_ill", 64'(ill64), 64'd0);
        issue(12'h003, C_READ, 64'd0);
        chk("lit_fcsr_rd", rd64, 64'hE5);
        chk("lit_frm", 64'(frm64), 64'd7);
        chk("lit_fflags", 64'(ff64), 64'h05);

        issue(12'h001, C_WRITE, 64'h01);
        issue(12'h001, C_CLEAR, 64'h1F, 1'b0, 2'b00, 5'h04);
        chk("lit_race_rdata", rd64, 64'h01);
        chk("lit_race_fflags", 64'(ff64), 64'h04);
        issue(12'h002, C_WRITE, 64'hFA);

        // Reset with a request pending, then count retirements from reset
        rst = 1'b1;
        req.csr_rw_addr = 12'h340; req.csr_rw_cmd = C_WRITE; req.csr_rw_data = 64'h55;
        @(posedge clk);
        #1;
        set_idle();
        rst = 1'b0;
        chk("lit_rst_pending_valid", 64'(v64), 64'd0);
        idle_cycle(2'b01);
        idle_cycle(2'b11);
        idle_cycle(2'b00);
        idle_cycle(2'b11);
        issue(12'hC02, C_READ, 64'd0);
        chk("lit_instret", rd64, 64'd5);
        issue(12'hB02, C_WRITE, 64'd100, 1'b0, 2'b11);
        issue(12'hB02, C_READ, 64'd0);
        chk("lit_minstret", rd64, 64'd100);
        issue(12'h340, C_READ, 64'd0);
        chk("lit_mscratch_after_rst", rd64, 64'd0);

        issue(12'hC00, C_WRITE, 64'h5);
        chk("lit_ro_valid", 64'(v64), 64'd1);
        chk("lit_ro_ill", 64'(ill64), 64'd1);
        chk("lit_ro_rdata", rd64, 64'd0);
        issue(12'h7C0, C_READ, 64'd0);
        chk("lit_unmapped_ill", 64'(ill64), 64'd1);
        issue(12'hC02, C_SET, 64'h1);
        issue(12'hC00, C_READ, 64'd0);

        issue(12'h340, C_WRITE, 64'hDEAD, 1'b1);
        chk("lit_exc_valid", 64'(v64), 64'd0);
        issue(12'h340, C_SYS, 64'hDEAD);
        chk("lit_sys_valid", 64'(v64), 64'd0);
        issue(12'h340, C_N2, 64'h1);
        issue(12'h001, C_VSELVL, 64'h1F);
        issue(12'h340, C_NOPE, 64'h1);
        issue(12'h340, C_READ, 64'd0);
        chk("lit_mscratch_zero", rd64, 64'd0);

        issue(12'h340, C_WRITE, 64'hF0F0);
        issue(12'h340, C_SET, 64'h000F);
        issue(12'h340, C_CLEAR, 64'h00F0);
        issue(12'h340, C_READ, 64'd0);
        chk("lit_mscratch_rmw", rd64, 64'hF00F);

        issue(12'hB00, C_WRITE, 64'hFF);
        issue(12'hB00, C_READ, 64'd0);
        chk("lit_mcycle8_ff", rd8, 64'hFF);
        issue(12'hC00, C_READ, 64'd0);
        chk("lit_cycle8_wrap", rd8, 64'h00);
        chk("lit_cycle64_nowrap", rd64, 64'h100);

        rst = 1'b1;
        req.csr_rw_addr = 12'h001; req.csr_rw_cmd = C_WRITE; req.csr_rw_data = 64'h1F;
        @(posedge clk);
        #1;
        set_idle();
        rst = 1'b0;
        chk("lit_rst2_valid", 64'(v64), 64'd0);
        chk("lit_rst2_fflags", 64'(ff64), 64'd0);
        chk("lit_rst2_frm", 64'(frm64), 64'd0);
        issue(12'hB00, C_READ, 64'd0);
        chk("lit_rst2_mcycle", rd64, 64'd0);
        issue(12'hB02, C_READ, 64'd0);
        chk("lit_rst2_minstret", rd64, 64'd0);
        issue(12'h003, C_READ, 64'd0);
        chk("lit_rst2_fcsr", rd64, 64'd0);
        issue(12'h340, C_READ, 64'd0);
        chk("lit_rst2_mscratch", rd64, 64'd0);

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
